// File: rtl/mrr_params.sv
// Shared constants and state encodings for the MRR SFO/CFO normalization path.
package mrr_params;

  localparam int PRIMARY_FFT_MAX_LEN_LOG2      = 10;
  localparam int SECONDARY_FFT_MAX_LEN_LOG2    = 6;
  localparam int PRIMARY_FFT_MAX_LEN_LOG2_LOG2 = 4;

  typedef enum logic [1:0] {
    ING_IDLE  = 2'd0,
    ING_RUN   = 2'd1,
    ING_STALL = 2'd2
  } ing_state_t;

  typedef enum logic [1:0] {
    RD_IDLE     = 2'd0,
    RD_PREFETCH = 2'd1,
    RD_ACTIVE   = 2'd2
  } rd_state_t;

  function automatic logic cfg_legal(
    input logic [PRIMARY_FFT_MAX_LEN_LOG2_LOG2-1:0] p_log2,
    input logic [PRIMARY_FFT_MAX_LEN_LOG2_LOG2-1:0] s_log2
  );
    cfg_legal = (p_log2 != '0) &&
                (p_log2 <= PRIMARY_FFT_MAX_LEN_LOG2_LOG2'(PRIMARY_FFT_MAX_LEN_LOG2)) &&
                (s_log2 <= PRIMARY_FFT_MAX_LEN_LOG2_LOG2'(SECONDARY_FFT_MAX_LEN_LOG2));
  endfunction

endpackage

// File: rtl/mrr_sfo_norm_readout.sv
// Per-bin shift readout: one prefetch cycle, then a valid/ready walk over bins 0..mask.
module mrr_sfo_norm_readout
  import mrr_params::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_clear,
  input  logic                                i_start,
  input  logic [PRIMARY_FFT_MAX_LEN_LOG2-1:0] i_mask,
  input  logic                                i_rd_ready,
  output logic                                o_rd_valid,
  output logic                                o_rd_last,
  output logic [PRIMARY_FFT_MAX_LEN_LOG2-1:0] o_rd_idx,
  output logic [PRIMARY_FFT_MAX_LEN_LOG2-1:0] o_rd_idx_next,
  output logic                                o_idle
);

  localparam int PL = PRIMARY_FFT_MAX_LEN_LOG2;

  rd_state_t       r_state, w_state_nxt;
  logic [PL-1:0]   r_k;
  logic            w_hs;

  assign w_hs     = (r_state == RD_ACTIVE) && i_rd_ready;
  assign o_rd_idx = r_k;
  assign o_idle   = (r_state == RD_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RD_IDLE;
      r_k     <= '0;
    end else if (i_clear) begin
      r_state <= RD_IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      // index parks at 0 after the last bin so the next readout starts clean
      if (w_hs) r_k <= o_rd_last ? '0 : r_k + PL'(1);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_rd_valid    = 1'b0;
    o_rd_last     = 1'b0;
    o_rd_idx_next = r_k;
    case (r_state)
      RD_IDLE:     if (i_start) w_state_nxt = RD_PREFETCH;
      RD_PREFETCH: w_state_nxt = RD_ACTIVE;
      RD_ACTIVE: begin
        o_rd_valid = 1'b1;
        o_rd_last  = (r_k == i_mask);
        if (w_hs) begin
          o_rd_idx_next = r_k + PL'(1);
          if (o_rd_last) w_state_nxt = RD_IDLE;
        end
      end
      default:     w_state_nxt = RD_IDLE;
    endcase
  end

endmodule

// File: rtl/mrr_sfo_norm_sequencer.sv
// Sequencer for the SFO/CFO magnitude-normalization stage: config, ingress gating,
// bin/secondary tracking and readout launch once a full secondary sweep lands.
module mrr_sfo_norm_sequencer
  import mrr_params::*;
(
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       clear,
  input  logic [PRIMARY_FFT_MAX_LEN_LOG2_LOG2-1:0]   cfg_primary_len_log2,
  input  logic [PRIMARY_FFT_MAX_LEN_LOG2_LOG2-1:0]   cfg_secondary_len_log2,
  input  logic                                       cfg_load,
  output logic                                       cfg_rejected,
  output logic [PRIMARY_FFT_MAX_LEN_LOG2_LOG2-1:0]   setting_primary_fft_len_log2,
  output logic [PRIMARY_FFT_MAX_LEN_LOG2:0]          setting_primary_fft_len_mask,
  output logic [SECONDARY_FFT_MAX_LEN_LOG2:0]        setting_secondary_fft_len_mask,
  input  logic                                       in_valid,
  input  logic                                       in_last,
  output logic                                       in_ready,
  output logic                                       norm_valid,
  output logic                                       norm_clear,
  output logic [PRIMARY_FFT_MAX_LEN_LOG2-1:0]        rd_idx_next,
  output logic                                       rd_valid,
  output logic                                       rd_last,
  input  logic                                       rd_ready,
  output logic [PRIMARY_FFT_MAX_LEN_LOG2-1:0]        rd_idx,
  output logic                                       busy,
  output logic                                       err_framing,
  output logic [15:0]                                sweep_count
);

  localparam int PL  = PRIMARY_FFT_MAX_LEN_LOG2;
  localparam int SL  = SECONDARY_FFT_MAX_LEN_LOG2;
  localparam int LW  = PRIMARY_FFT_MAX_LEN_LOG2_LOG2;
  localparam int PMW = PL + 1;
  localparam int SMW = SL + 1;

  ing_state_t     r_ing, w_ing_nxt;
  logic [PL-1:0]  r_b;
  logic [SL-1:0]  r_s;
  logic [LW-1:0]  r_p_log2;
  logic [PMW-1:0] r_p_mask;
  logic [SMW-1:0] r_s_mask;
  logic           r_cfg_rej, r_norm_clr, r_err;
  logic [15:0]    r_sweeps;

  logic w_rd_idle, w_b_wrap, w_s_wrap, w_stall, w_acc, w_done, w_rd_start;
  logic w_cfg_req, w_cfg_apply;

  assign w_b_wrap   = (r_b == r_p_mask[PL-1:0]);
  assign w_s_wrap   = (r_s == r_s_mask[SL-1:0]);
  // the final secondary FFT rewrites the normalizer buffer, so it waits for readout
  assign w_stall    = w_s_wrap && (r_b == '0) && !w_rd_idle;
  assign w_acc      = in_valid && in_ready;
  assign w_done     = w_acc && w_b_wrap && w_s_wrap;
  assign w_rd_start = w_done && !clear;

  assign busy        = (r_ing != ING_IDLE) || !w_rd_idle;
  assign w_cfg_req   = cfg_load && !clear;
  assign w_cfg_apply = w_cfg_req && !busy &&
                       cfg_legal(cfg_primary_len_log2, cfg_secondary_len_log2);

  assign norm_valid                     = w_acc;
  assign norm_clear                     = r_norm_clr;
  assign cfg_rejected                   = r_cfg_rej;
  assign err_framing                    = r_err;
  assign sweep_count                    = r_sweeps;
  assign setting_primary_fft_len_log2   = r_p_log2;
  assign setting_primary_fft_len_mask   = r_p_mask;
  assign setting_secondary_fft_len_mask = r_s_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_log2  <= LW'(PL);
      r_p_mask  <= PMW'((32'd1 << PL) - 32'd1);
      r_s_mask  <= '0;
      r_cfg_rej <= 1'b0;
    end else begin
      r_cfg_rej <= w_cfg_req && !w_cfg_apply;
      if (w_cfg_apply) begin
        r_p_log2 <= cfg_primary_len_log2;
        r_p_mask <= PMW'((32'd1 << cfg_primary_len_log2) - 32'd1);
        r_s_mask <= SMW'((32'd1 << cfg_secondary_len_log2) - 32'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ing      <= ING_IDLE;
      r_b        <= '0;
      r_s        <= '0;
      r_sweeps   <= '0;
      r_norm_clr <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_norm_clr <= clear;
      if (clear) begin
        r_ing    <= ING_IDLE;
        r_b      <= '0;
        r_s      <= '0;
        r_sweeps <= '0;
      end else begin
        r_ing <= w_ing_nxt;
        if (w_acc) begin
          // framing errors are only flagged; counters keep running until a clear
          if (in_last != w_b_wrap) r_err <= 1'b1;
          if (w_b_wrap) begin
            r_b <= '0;
            r_s <= w_s_wrap ? '0 : r_s + SL'(1);
          end else begin
            r_b <= r_b + PL'(1);
          end
          if (w_done) r_sweeps <= r_sweeps + 16'd1;
        end
      end
    end
  end

  always_comb begin
    w_ing_nxt = r_ing;
    in_ready  = 1'b0;
    case (r_ing)
      ING_IDLE: begin
        in_ready = !clear && !w_stall;
        if (w_acc) w_ing_nxt = w_done ? ING_IDLE : ING_RUN;
      end
      ING_RUN: begin
        in_ready = !clear && !w_stall;
        if (w_done)       w_ing_nxt = ING_IDLE;
        else if (w_stall) w_ing_nxt = ING_STALL;
      end
      ING_STALL: if (w_rd_idle) w_ing_nxt = ING_RUN;
      default:   w_ing_nxt = ING_IDLE;
    endcase
  end

  mrr_sfo_norm_readout u_readout (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (clear),
    .i_start       (w_rd_start),
    .i_mask        (r_p_mask[PL-1:0]),
    .i_rd_ready    (rd_ready),
    .o_rd_valid    (rd_valid),
    .o_rd_last     (rd_last),
    .o_rd_idx      (rd_idx),
    .o_rd_idx_next (rd_idx_next),
    .o_idle        (w_rd_idle)
  );

endmodule

// File: tb/tb_mrr_sfo_norm_sequencer.sv
// Directed bench for mrr_sfo_norm_sequencer; readout beats are scored against a queue.
module tb_mrr_sfo_norm_sequencer;
  import mrr_params::*;

  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, cfg_load = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, rd_ready = 1'b0;
  logic [3:0]  cfg_p = 4'd0, cfg_s = 4'd0;
  logic        cfg_rejected, in_ready, norm_valid, norm_clear;
  logic        rd_valid, rd_last, busy, err_framing;
  logic [3:0]  p_log2;
  logic [10:0] p_mask;
  logic [6:0]  s_mask;
  logic [9:0]  rd_idx_next, rd_idx;
  logic [15:0] sweep_count;

  int          n_chk = 0, n_fail = 0, hs_cnt = 0, nv_cnt = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  exp_last = 10'd7;
  logic [9:0]  mon_e;

  always #5 clk = ~clk;

  mrr_sfo_norm_sequencer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .cfg_primary_len_log2(cfg_p), .cfg_secondary_len_log2(cfg_s), .cfg_load(cfg_load),
    .cfg_rejected(cfg_rejected),
    .setting_primary_fft_len_log2(p_log2),
    .setting_primary_fft_len_mask(p_mask),
    .setting_secondary_fft_len_mask(s_mask),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .norm_valid(norm_valid), .norm_clear(norm_clear),
    .rd_idx_next(rd_idx_next), .rd_valid(rd_valid), .rd_last(rd_last),
    .rd_ready(rd_ready), .rd_idx(rd_idx),
    .busy(busy), .err_framing(err_framing), .sweep_count(sweep_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic last);
    int n = 0;
    in_valid = 1'b1; in_last = last; #1;
    while (!in_ready && n < 200) begin tick(); #1; n++; end
    chk("send_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) send((i % 8) == 7);
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(10'(i));
  endtask

  // runs the readout until the rd_last handshake edge has passed
  task automatic drain(input bit toggle);
    int  n = 0;
    bit  done = 0;
    while (n < 100) begin
      if (toggle) rd_ready = n[0];
      #1;
      if (rd_valid && rd_ready && rd_last) begin done = 1; break; end
      @(posedge clk); #1; n++;
    end
    chk("drain_done", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (norm_valid) nv_cnt++;
      if (rd_valid && rd_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("rd_unexpected_beat", 32'(rd_idx), 32'hFFFF_FFFF);
        else begin
          mon_e = exp_q.pop_front();
          chk("rd_idx", 32'(rd_idx), 32'(mon_e));
          chk("rd_idx_next_hs", 32'(rd_idx_next), 32'(10'(mon_e + 10'd1)));
          chk("rd_last", 32'(rd_last), 32'(mon_e == exp_last));
        end
      end else if (rd_valid) begin
        chk("rd_idx_next_stalled", 32'(rd_idx_next), 32'(rd_idx));
      end
    end
  end

  initial begin
    int nv0, n;
    repeat (2) @(posedge clk); #1;
    chk("rst_p_log2", 32'(p_log2), 32'd10);
    chk("rst_p_mask", 32'(p_mask), 32'h3FF);
    chk("rst_s_mask", 32'(s_mask), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_sweeps", 32'(sweep_count), 32'd0);
    chk("rst_err", 32'(err_framing), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1; tick();

    cfg_p = 4'd3; cfg_s = 4'd2; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    chk("cfg_p_log2", 32'(p_log2), 32'd3);
    chk("cfg_p_mask", 32'(p_mask), 32'h7);
    chk("cfg_s_mask", 32'(s_mask), 32'h3);
    chk("cfg_no_reject", 32'(cfg_rejected), 32'd0);

    // basic sweep
    hs_cnt = 0; push_exp(8); rd_ready = 1'b1;
    sweep(32);
    chk("basic_sweeps", 32'(sweep_count), 32'd1);
    chk("basic_prefetch_valid", 32'(rd_valid), 32'd0);
    chk("basic_prefetch_busy", 32'(busy), 32'd1);
    chk("basic_prefetch_next", 32'(rd_idx_next), 32'd0);
    tick();
    chk("basic_first_valid", 32'(rd_valid), 32'd1);
    chk("basic_first_idx", 32'(rd_idx), 32'd0);
    drain(0);
    chk("basic_busy_drop", 32'(busy), 32'd0);
    chk("basic_hs", 32'(hs_cnt), 32'd8);
    chk("basic_err", 32'(err_framing), 32'd0);

    // backpressure
    hs_cnt = 0; push_exp(8);
    sweep(32);
    chk("bp_sweeps", 32'(sweep_count), 32'd2);
    drain(1);
    chk("bp_hs", 32'(hs_cnt), 32'd8);
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // overlap stall
    rd_ready = 1'b0; hs_cnt = 0; push_exp(8);
    sweep(32);
    chk("ov_sweeps", 32'(sweep_count), 32'd3);
    sweep(24);
    #1;
    chk("ov_stall_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; nv0 = nv_cnt;
    repeat (4) tick();
    chk("ov_no_accept", 32'(nv_cnt - nv0), 32'd0);
    in_valid = 1'b0;
    rd_ready = 1'b1;
    drain(0);
    chk("ov_hs", 32'(hs_cnt), 32'd8);
    chk("ov_wait_ready", 32'(in_ready), 32'd0);
    tick();
    chk("ov_resume_ready", 32'(in_ready), 32'd1);
    push_exp(8);
    sweep(8);
    chk("ov_final_sweeps", 32'(sweep_count), 32'd4);
    drain(0);
    chk("ov_q_empty", 32'(exp_q.size()), 32'd0);

    // config rejection and clear priority
    sweep(3);
    cfg_p = 4'd4; cfg_s = 4'd1; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    chk("rej_busy_pulse", 32'(cfg_rejected), 32'd1);
    chk("rej_busy_pmask", 32'(p_mask), 32'h7);
    chk("rej_busy_smask", 32'(s_mask), 32'h3);
    tick();
    chk("rej_pulse_end", 32'(cfg_rejected), 32'd0);
    clear = 1'b1; cfg_load = 1'b1; in_valid = 1'b1; #1;
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    chk("clr_norm_valid", 32'(norm_valid), 32'd0);
    tick(); clear = 1'b0; cfg_load = 1'b0; in_valid = 1'b0;
    chk("clr_norm_clear", 32'(norm_clear), 32'd1);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_sweeps", 32'(sweep_count), 32'd0);
    chk("clr_cfg_ignored", 32'(cfg_rejected), 32'd0);
    chk("clr_pmask_kept", 32'(p_mask), 32'h7);
    tick();
    chk("clr_norm_clear_end", 32'(norm_clear), 32'd0);
    cfg_p = 4'd0; cfg_s = 4'd2; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    chk("rej_p0_pulse", 32'(cfg_rejected), 32'd1);
    chk("rej_p0_pmask", 32'(p_mask), 32'h7);
    cfg_p = 4'd3; cfg_s = 4'd7; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    chk("rej_s7_pulse", 32'(cfg_rejected), 32'd1);
    chk("rej_s7_smask", 32'(s_mask), 32'h3);

    // framing
    for (int i = 0; i < 5; i++) send(1'b0);
    send(1'b1);
    chk("frm_err", 32'(err_framing), 32'd1);
    clear = 1'b1; tick(); clear = 1'b0; tick();
    chk("frm_sticky", 32'(err_framing), 32'd1);

    // async reset mid-readout
    push_exp(4); rd_ready = 1'b1;
    sweep(32);
    n = 0;
    while (!(rd_valid && rd_idx == 10'd4) && n < 50) begin tick(); n++; end
    rd_ready = 1'b0;
    chk("ar_reach_idx4", 32'(rd_idx), 32'd4);
    #2; rst_n = 1'b0; #1;
    chk("ar_rd_valid", 32'(rd_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_p_log2", 32'(p_log2), 32'd10);
    chk("ar_p_mask", 32'(p_mask), 32'h3FF);
    chk("ar_s_mask", 32'(s_mask), 32'h0);
    chk("ar_err", 32'(err_framing), 32'd0);
    chk("ar_sweeps", 32'(sweep_count), 32'd0);
    chk("ar_q_empty", 32'(exp_q.size()), 32'd0);
    tick(); rst_n = 1'b1; tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
